// File: rtl/wrr_pkg.sv
// Shared types and sizing for the weighted round-robin arbiter.
// Imported by the picker and the arbitration core.
package wrr_pkg;

  localparam int N_REQ  = 32;
  localparam int ID_W   = 5;
  localparam int PRIO_W = 4;

  typedef logic [PRIO_W-1:0] prio_t;
  typedef logic [ID_W-1:0]   id_t;
  typedef logic [N_REQ-1:0]  req_vec_t;

  localparam prio_t RST_WEIGHT = prio_t'(1);

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating first-eligible search starting just after start.
// start itself is the last candidate (wraps through the full ring).
module wrr_rr_pick
  import wrr_pkg::*;
(
  input  req_vec_t elig,
  input  id_t      start,
  output logic     found,
  output id_t      id
);

  logic [2*N_REQ-1:0] dbl;
  logic [ID_W:0]      sh;
  req_vec_t           rot;
  id_t                k;

  // Rotate via double-width shift, then lowest-set-bit encode.
  always_comb begin
    sh    = {1'b0, start} + (ID_W+1)'(1);
    dbl   = {elig, elig} >> sh;
    rot   = dbl[N_REQ-1:0];
    found = |rot;
    k     = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) k = id_t'(i);
    end
    id = start + k + id_t'(1);
  end

endmodule

// File: rtl/wrr_arbiter_core.sv
// Weighted round-robin arbitration core with internal weight table.
// Owner keeps the grant for up to weight[owner] consecutive cycles.
module wrr_arbiter_core
  import wrr_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  prio_t    prio,
  input  id_t      prio_id,
  input  logic     prio_upt,
  input  req_vec_t req,
  output req_vec_t gnt,
  output id_t      gnt_id,
  output logic     gnt_vld
);

  prio_t      weight [N_REQ];
  arb_state_e state, state_n;
  id_t        owner, owner_n;
  prio_t      cnt, cnt_n;
  req_vec_t   gnt_n;
  id_t        gnt_id_n;
  logic       gnt_vld_n;
  req_vec_t   elig;
  logic       found;
  id_t        pick_id;
  logic       keep;

  // Weight 0 masks a requester out entirely.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && (weight[i] != '0);
    end
  end

  wrr_rr_pick u_pick (
    .elig  (elig),
    .start (owner),
    .found (found),
    .id    (pick_id)
  );

  // Weight table; reset reload wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) weight[i] <= RST_WEIGHT;
    end else if (prio_upt) begin
      weight[prio_id] <= prio;
    end
  end

  // Next-state: hold the burst or rotate to the next eligible requester.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    cnt_n     = cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    gnt_vld_n = gnt_vld;
    keep      = (state == BURST) && elig[owner]
                && (cnt < weight[owner]);
    if (keep) begin
      cnt_n = cnt + prio_t'(1);
    end else if (found) begin
      state_n   = BURST;
      owner_n   = pick_id;
      cnt_n     = prio_t'(1);
      gnt_n     = req_vec_t'(1) << pick_id;
      gnt_id_n  = pick_id;
      gnt_vld_n = 1'b1;
    end else begin
      state_n   = IDLE;
      cnt_n     = '0;
      gnt_n     = '0;
      gnt_id_n  = '0;
      gnt_vld_n = 1'b0;
    end
  end

  // Registered arbitration state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= id_t'(N_REQ-1);
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      gnt_id  <= gnt_id_n;
      gnt_vld <= gnt_vld_n;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter_core.sv
// Randomized and directed bench for wrr_arbiter_core.
// Reference model tracks owner/burst with plain integers.
module tb_wrr_arbiter_core;
  import wrr_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  prio_t    prio;
  id_t      prio_id;
  logic     prio_upt;
  req_vec_t req;
  req_vec_t gnt;
  id_t      gnt_id;
  logic     gnt_vld;

  int errors = 0;
  int checks = 0;

  int       m_w [32];
  int       m_owner;
  int       m_cnt;
  bit       m_busy;
  req_vec_t exp_gnt;
  id_t      exp_id;
  logic     exp_vld;

  always #5 clk = ~clk;

  wrr_arbiter_core dut (
    .clk      (clk),
    .rst      (rst),
    .prio     (prio),
    .prio_id  (prio_id),
    .prio_upt (prio_upt),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld)
  );

  function automatic bit m_elig(int i, req_vec_t r);
    return r[i] && (m_w[i] != 0);
  endfunction

  task automatic m_step(input logic r, input req_vec_t rq,
                        input logic u, input int id, input int p);
    int idx;
    bit hit;
    if (r) begin
      for (int i = 0; i < 32; i++) m_w[i] = 1;
      m_owner = 31;
      m_cnt   = 0;
      m_busy  = 0;
    end else begin
      if (m_busy && m_elig(m_owner, rq) && m_cnt < m_w[m_owner]) begin
        m_cnt++;
      end else begin
        hit = 0;
        for (int k = 1; k <= 32 && !hit; k++) begin
          idx = (m_owner + k) % 32;
          if (m_elig(idx, rq)) hit = 1;
        end
        if (hit) begin
          m_owner = idx;
          m_cnt   = 1;
          m_busy  = 1;
        end else begin
          m_cnt  = 0;
          m_busy = 0;
        end
      end
      if (u) m_w[id] = p;
    end
    exp_vld = m_busy;
    exp_id  = m_busy ? id_t'(m_owner) : '0;
    exp_gnt = m_busy ? (req_vec_t'(1) << m_owner) : '0;
  endtask

  task automatic tick(input logic r, input req_vec_t rq,
                      input logic u, input int id, input int p);
    @(negedge clk);
    rst      = r;
    req      = rq;
    prio_upt = u;
    prio_id  = id_t'(id);
    prio     = prio_t'(p);
    @(posedge clk);
    m_step(r, rq, u, id, p);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, '1, 0, 0, 0);
      checks++;
      if ({gnt, gnt_id, gnt_vld} !== '0) begin
        errors++;
        $display("FAIL reset: gnt=%h id=%0d vld=%b want 0",
                 gnt, gnt_id, gnt_vld);
      end
    end
    tick(0, '1, 0, 0, 0);
    checks++;
    if (gnt !== 32'h1 || gnt_id !== 5'd0 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%h id=%0d vld=%b want 1/0/1",
               gnt, gnt_id, gnt_vld);
    end
  endtask

  task automatic test_weighting();
    int seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    tick(1, '0, 0, 0, 0);
    tick(0, '0, 1, 0, 3);
    for (int i = 0; i < 8; i++) begin
      tick(0, 32'h3, 0, 0, 0);
      checks++;
      if (gnt_id !== id_t'(seq[i]) || gnt_vld !== 1'b1 ||
          gnt !== exp_gnt) begin
        errors++;
        $display("FAIL weighting[%0d]: id=%0d vld=%b want %0d",
                 i, gnt_id, gnt_vld, seq[i]);
      end
    end
  endtask

  task automatic test_mask_wrap();
    int seq [3] = '{31, 0, 31};
    tick(1, '0, 0, 0, 0);
    tick(0, '0, 1, 5, 0);
    tick(0, 32'h4000_0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 32'h8000_0021, 0, 0, 0);
      checks++;
      if (gnt_id !== id_t'(seq[i]) || gnt_vld !== 1'b1 ||
          gnt[5] !== 1'b0) begin
        errors++;
        $display("FAIL mask_wrap[%0d]: id=%0d gnt=%h want %0d",
                 i, gnt_id, gnt, seq[i]);
      end
    end
  endtask

  task automatic test_mid_burst();
    int seq [5] = '{2, 2, 2, 2, 3};
    tick(1, '0, 0, 0, 0);
    tick(0, '0, 1, 2, 8);
    for (int i = 0; i < 5; i++) begin
      tick(0, 32'hC, (i == 3), 2, 2);
      checks++;
      if (gnt_id !== id_t'(seq[i]) || gnt !== exp_gnt) begin
        errors++;
        $display("FAIL mid_burst[%0d]: id=%0d want %0d",
                 i, gnt_id, seq[i]);
      end
    end
  endtask

  task automatic test_same_edge();
    tick(1, '0, 0, 0, 0);
    tick(0, 32'h10, 1, 4, 0);
    checks++;
    if (gnt_id !== 5'd4 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL same_edge: id=%0d vld=%b want 4/1",
               gnt_id, gnt_vld);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 32'h50, 0, 0, 0);
      checks++;
      if (gnt_id !== 5'd6 || gnt[4] !== 1'b0) begin
        errors++;
        $display("FAIL same_edge_mask[%0d]: id=%0d want 6", i, gnt_id);
      end
    end
  endtask

  task automatic test_drop_idle();
    int seq [5] = '{7, 7, 7, 7, 8};
    tick(1, '0, 0, 0, 0);
    tick(0, '0, 1, 7, 4);
    tick(0, 32'h80, 0, 0, 0);
    tick(0, 32'h80, 0, 0, 0);
    tick(0, '0, 0, 0, 0);
    checks++;
    if ({gnt, gnt_id, gnt_vld} !== '0) begin
      errors++;
      $display("FAIL drop: gnt=%h id=%0d vld=%b want 0",
               gnt, gnt_id, gnt_vld);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, (i == 0) ? 32'h80 : 32'h180, 0, 0, 0);
      checks++;
      if (gnt_id !== id_t'(seq[i]) || gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL fresh_burst[%0d]: id=%0d want %0d",
                 i, gnt_id, seq[i]);
      end
    end
  endtask

  task automatic test_random();
    req_vec_t mask, rq;
    logic r, u;
    tick(1, '0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0:       mask = 32'h0000_00FF;
        1:       mask = 32'hF000_000F;
        default: mask = '1;
      endcase
      rq = req_vec_t'($urandom) & mask;
      if ($urandom_range(0, 7) == 0) rq = '0;
      r = ($urandom_range(0, 63) == 0);
      u = ($urandom_range(0, 3) == 0);
      tick(r, rq, u, $urandom_range(0, 31), $urandom_range(0, 15));
      checks++;
      if ({gnt, gnt_id, gnt_vld} !== {exp_gnt, exp_id, exp_vld}) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%h id=%0d vld=%b want %h/%0d/%b",
                 i, gnt, gnt_id, gnt_vld, exp_gnt, exp_id, exp_vld);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    prio     = '0;
    prio_id  = '0;
    prio_upt = 1'b0;
    test_reset();
    test_weighting();
    test_mask_wrap();
    test_mid_burst();
    test_same_edge();
    test_drop_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter_core.md
Name: wrr_arbiter_core

Overview:
Weighted round-robin arbitration core. It consumes the priority-update stream (prio / prio_id / prio_upt) driven by the prio_update agent and the DUT's upstream configuration port. A 32-entry weight table is held internally. Each granted requester keeps the grant for up to weight[id] consecutive cycles, then ownership rotates to the next eligible requester.

Parameters:
N_REQ, 32, number of requesters
ID_W, 5, requester index width (= $clog2(N_REQ))
PRIO_W, 4, weight width
RST_WEIGHT, 1, weight loaded into every table entry at reset (plain round robin)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
prio  input  PRIO_W  new weight value
prio_id  input  ID_W  table entry to write
prio_upt  input  1  write strobe, single-cycle, no backpressure
req  input  N_REQ  per-requester request level
gnt  output  N_REQ  one-hot grant, registered
gnt_id  output  ID_W  index of granted requester, registered
gnt_vld  output  1  gnt/gnt_id valid this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - weight[i]=RST_WEIGHT for all i
  - gnt=0, gnt_id=0, gnt_vld=0
  - owner=N_REQ-1, so the first search starts at index 0
  - cnt=0, state=IDLE
- Eligible vector: elig[i] = req[i] && (weight[i] != 0). Weight 0 disables requester i.
- Latency: decision uses req and weight sampled at posedge N; result appears on gnt/gnt_id/gnt_vld after posedge N. That is 1 cycle from req to gnt.
- cnt: number of consecutive grant cycles already issued to owner. Width PRIO_W; it never exceeds 15.
- States:
  - IDLE: no owner holds.
    - elig!=0 -> pick, cnt=1, go to BURST.
    - elig==0 -> gnt_vld=0, stay IDLE, owner unchanged.
  - BURST:
    - If elig[owner] && cnt < weight[owner]: keep the same grant, cnt++.
    - Else: pick.
      - Found -> new owner, cnt=1, stay BURST.
      - None -> gnt=0, gnt_vld=0, cnt=0, go to IDLE; owner pointer retained.
- pick: rotating search from owner+1 upward, modulo N_REQ (31 wraps to 0). Returns the first elig index.
  - owner itself is eligible only as the last candidate, e.g. a sole requester is re-granted after its burst with cnt=1.
- Weight update: at posedge with prio_upt=1, weight[prio_id] <= prio.
  - The arbitration decision at that same edge uses the old table. The new value applies from the next edge.
  - Updating the current owner to a weight <= cnt releases it at the next decision.
  - Updating it to 0 releases it immediately at the next decision.
- Request drop mid-burst: owner loses the grant at the next edge (no dangling grant). cnt is discarded.
- gnt is always one-hot or zero. gnt_vld == |gnt. gnt_id == 0 when gnt_vld == 0.
- rst asserted mid-burst: all state returns to reset values at that edge, and the weight table is reloaded. Any prio_upt on the same edge is ignored.
- No combinational path from any input to any output.

Decomposition:
- Package wrr_pkg holds:
  - localparams N_REQ, ID_W, PRIO_W
  - typedefs prio_t (logic [PRIO_W-1:0]), id_t (logic [ID_W-1:0]), req_vec_t (logic [N_REQ-1:0])
  - enum arb_state_e {IDLE, BURST}
- One combinational sub-module, wrr_rr_pick:
  - Inputs: elig vector, start pointer.
  - Outputs: found and next id.
  - Implemented as a double-width masked priority encoder.
  - Unit-testable on its own.

Test Plan:
- Reset check: assert rst for 2 cycles with req=all ones -> gnt=0, gnt_vld=0, gnt_id=0. First grant after release is id 0, one cycle after req is sampled.
- Weighting: weight[0]=3, weight[1]=1, req=0x3 held -> gnt_id sequence 0,0,0,1,0,0,0,1 repeating.
- Masking and wrap: weight[5]=0, req bits 5 and 31 and 0 set, owner=30 -> grants 31, then 0, then 31. Id 5 is never granted.
- Mid-burst update: weight[2]=8, owner=2 with cnt=3, prio_upt writes weight[2]=2 -> owner released at the following decision; the next eligible requester is granted.
- Same-edge update: prio_upt writes weight[4]=0 on the same edge a grant to 4 is decided -> that grant issues. Requester 4 is never granted again while its weight is 0.
- Request drop and idle: owner 7 mid-burst deasserts req, no other req -> next cycle gnt_vld=0, gnt=0. A later req on 7 alone -> grant 7 with a fresh burst (cnt=1).
